// File: rtl/btn_sw_dev_in_pkg.sv
// Shared widths, register-select encodings and read-word packing for the
// switch/button input device.
package btn_sw_dev_in_pkg;

  localparam int unsigned N_SW   = 8;
  localparam int unsigned N_BTN  = 5;
  localparam int unsigned N_IN   = N_SW + N_BTN;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ADDR_STAT  = 2'b00,
    ADDR_CAPT  = 2'b01,
    ADDR_IRQEN = 2'b10,
    ADDR_RSVD  = 2'b11
  } addr_e;

  // Status word layout: debounced buttons above debounced switches.
  typedef struct packed {
    logic [DATA_W-N_IN-1:0] pad;
    logic [N_BTN-1:0]       btn;
    logic [N_SW-1:0]        sw;
  } stat_word_t;

  function automatic logic [DATA_W-1:0] pack_stat(
    input logic [N_BTN-1:0] btn,
    input logic [N_SW-1:0]  sw
  );
    stat_word_t w;
    w     = '0;
    w.btn = btn;
    w.sw  = sw;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] pack_capt(input logic [N_BTN-1:0] capt);
    return {{(DATA_W-N_BTN){1'b0}}, capt};
  endfunction

  function automatic logic [DATA_W-1:0] pack_irq_en(input logic irq_en);
    return {{(DATA_W-1){1'b0}}, irq_en};
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a settle counter that only
// lets the stable value follow the synced value after DB_CYCLES agreement.
module debounce_bit #(
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int unsigned    CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;

  // Counter runs only while synced disagrees with stable; it stops at CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sync1 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_sw_dev_in.sv
// Memory-mapped switch/button device: debounced status, sticky button-press
// capture with write-1-to-clear, and a level interrupt gated by irq_en.
module btn_sw_dev_in
  import btn_sw_dev_in_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SW-1:0]   sw_in,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic              GPIOe0000000_we,
  input  logic [1:0]        addr_sel,
  input  logic [DATA_W-1:0] Peripheral_in,
  output logic [DATA_W-1:0] Peripheral_out,
  output logic              btn_irq
);

  logic [N_IN-1:0]   raw_c;
  logic [N_IN-1:0]   stable;
  logic [N_BTN-1:0]  btn_stable_c;
  logic [N_SW-1:0]   sw_stable_c;
  logic [N_BTN-1:0]  btn_prev;
  logic [N_BTN-1:0]  capture;
  logic              irq_en;
  addr_e             addr_c;
  logic [N_BTN-1:0]  rise_c;
  logic [N_BTN-1:0]  clr_c;
  logic [N_BTN-1:0]  capture_nxt_c;
  logic              irq_en_we_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              unused_pin_c;

  assign raw_c        = {btn_in, sw_in};
  assign btn_stable_c = stable[N_IN-1:N_SW];
  assign sw_stable_c  = stable[N_SW-1:0];
  assign unused_pin_c = ^Peripheral_in[DATA_W-1:N_BTN];

  for (genvar i = 0; i < int'(N_IN); i++) begin : g_db
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_c[i]),
      .stable(stable[i])
    );
  end

  // Capture update (set beats clear) and read mux over pre-write state.
  always_comb begin
    addr_c        = addr_e'(addr_sel);
    rise_c        = btn_stable_c & ~btn_prev;
    clr_c         = '0;
    irq_en_we_c   = 1'b0;
    rd_data_c     = '0;
    if (GPIOe0000000_we && addr_c == ADDR_CAPT) begin
      clr_c = Peripheral_in[N_BTN-1:0];
    end
    if (GPIOe0000000_we && addr_c == ADDR_IRQEN) begin
      irq_en_we_c = 1'b1;
    end
    capture_nxt_c = (capture & ~clr_c) | rise_c;
    case (addr_c)
      ADDR_STAT:  rd_data_c = pack_stat(btn_stable_c, sw_stable_c);
      ADDR_CAPT:  rd_data_c = pack_capt(capture);
      ADDR_IRQEN: rd_data_c = pack_irq_en(irq_en);
      default:    rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev       <= '0;
      capture        <= '0;
      irq_en         <= 1'b0;
      Peripheral_out <= '0;
      btn_irq        <= 1'b0;
    end else begin
      btn_prev       <= btn_stable_c;
      capture        <= capture_nxt_c;
      if (irq_en_we_c) begin
        irq_en <= Peripheral_in[0];
      end
      Peripheral_out <= rd_data_c;
      btn_irq        <= irq_en & (|capture);
    end
  end

endmodule

// File: tb/tb_btn_sw_dev_in.sv
// Directed and randomized bench for btn_sw_dev_in with a window-based
// reference model of debounce, capture, irq and the read map.
module tb_btn_sw_dev_in;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw_in;
  logic [4:0]  btn_in;
  logic        we;
  logic [1:0]  addr_sel;
  logic [31:0] pin;
  logic [31:0] pout;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  btn_sw_dev_in #(.DB_CYCLES(DB)) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_in          (sw_in),
    .btn_in         (btn_in),
    .GPIOe0000000_we(we),
    .addr_sel       (addr_sel),
    .Peripheral_in  (pin),
    .Peripheral_out (pout),
    .btn_irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference state: raw seen by the debouncer arrives two edges late; a bit's
  // stable value flips once the last DB seen samples all disagree with it.
  logic [12:0] m_d1, m_d2, m_stable, m_prev;
  logic [12:0] m_win[$];
  logic [4:0]  m_capt;
  logic        m_irq_en;
  logic [31:0] m_out;
  logic        m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_stable = '0; m_prev = '0;
    m_capt = '0; m_irq_en = 1'b0; m_out = '0; m_irq = 1'b0;
    m_win.delete();
    for (int k = 0; k < DB; k++) m_win.push_back(13'h0);
  endtask

  task automatic model_step();
    logic [12:0] nstab;
    logic [4:0]  clr;
    logic        all_diff;
    m_win.push_back(m_d2);
    if (m_win.size() > DB) void'(m_win.pop_front());
    nstab = m_stable;
    for (int b = 0; b < 13; b++) begin
      all_diff = 1'b1;
      foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) nstab[b] = ~m_stable[b];
    end
    case (addr_sel)
      2'd0:    m_out = {19'b0, m_stable};
      2'd1:    m_out = {27'b0, m_capt};
      2'd2:    m_out = {31'b0, m_irq_en};
      default: m_out = 32'h0;
    endcase
    m_irq = m_irq_en & (m_capt != 5'b0);
    clr   = (we && addr_sel == 2'd1) ? pin[4:0] : 5'b0;
    m_capt = (m_capt & ~clr) | (m_stable[12:8] & ~m_prev[12:8]);
    if (we && addr_sel == 2'd2) m_irq_en = pin[0];
    m_prev   = m_stable;
    m_stable = nstab;
    m_d2     = m_d1;
    m_d1     = {btn_in, sw_in};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check("model_pout", pout, m_out);
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr_sel = a; pin = d;
    tick();
    we = 1'b0; pin = $urandom();
  endtask

  initial begin
    rst = 1'b1; sw_in = '0; btn_in = '0; we = 1'b0; addr_sel = 2'd0; pin = '0;
    model_reset();
    repeat (3) tick();
    check("reset_pout", pout, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;

    // Switches settle and appear in the status word.
    sw_in = 8'hA5;
    repeat (10) tick();
    check("sw_a5", pout, 32'h0000_00A5);

    // Short button glitch is rejected.
    btn_in[2] = 1'b1;
    repeat (3) tick();
    btn_in[2] = 1'b0;
    addr_sel = 2'd1;
    repeat (8) tick();
    check("glitch_capt", pout, 32'h0);
    addr_sel = 2'd0;
    tick();
    check("glitch_stat", pout, 32'h0000_00A5);

    // Held press: capture at edge 7, visible on the read port one edge later.
    addr_sel = 2'd1;
    btn_in[2] = 1'b1;
    repeat (6) tick();
    btn_in[2] = 1'b0;
    tick();
    check("capt_edge7", pout, 32'h0);
    tick();
    check("capt_edge8", pout, 32'h4);
    repeat (10) tick();

    btn_in[4] = 1'b1;
    repeat (10) tick();
    btn_in[4] = 1'b0;
    repeat (10) tick();
    check("capt_10100", pout, 32'h14);
    wr(2'd1, 32'h4);
    check("read_prewrite", pout, 32'h14);
    tick();
    check("w1c_bit2", pout, 32'h10);

    // Clear coinciding with a new bit-4 edge: set wins.
    btn_in[4] = 1'b1;
    repeat (6) tick();
    wr(2'd1, 32'h10);
    tick();
    check("set_wins", pout, 32'h10);
    btn_in[4] = 1'b0;
    repeat (10) tick();
    wr(2'd1, 32'h10);
    tick();
    check("clr_bit4", pout, 32'h0);

    // Reserved-address writes do nothing.
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    addr_sel = 2'd2;
    tick();
    tick();
    check("rsvd_wr", pout, 32'h0);

    // Interrupt enable and 1-cycle lag on both edges of btn_irq.
    btn_in[1] = 1'b1;
    repeat (10) tick();
    btn_in[1] = 1'b0;
    repeat (10) tick();
    wr(2'd2, 32'h1);
    check("irq_lag", {31'b0, irq}, 32'h0);
    tick();
    check("irq_on", {31'b0, irq}, 32'h1);
    check("irq_en_rd", pout, 32'h1);
    wr(2'd1, 32'h1F);
    check("irq_hold", {31'b0, irq}, 32'h1);
    tick();
    check("irq_off", {31'b0, irq}, 32'h0);

    // Asynchronous reset in the middle of a button settle.
    addr_sel = 2'd0;
    tick();
    btn_in[0] = 1'b1;
    repeat (4) tick();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_pout", pout, 32'h0);
    check("rst_async_irq", {31'b0, irq}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    addr_sel = 2'd1;
    repeat (7) tick();
    check("rst_capt_edge7", pout, 32'h0);
    tick();
    check("rst_capt_edge8", pout, 32'h1);
    addr_sel = 2'd2;
    tick();
    tick();
    check("rst_irq_en", pout, 32'h0);
    btn_in[0] = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 11) == 0) sw_in[b] = ~sw_in[b];
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 11) == 0) btn_in[b] = ~btn_in[b];
      addr_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        we  = 1'b1;
        pin = $urandom();
      end else begin
        we = 1'b0;
      end
      tick();
    end
    we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_sw_dev_in.md
BTN_SW_DEV_IN -- requirements
Module: btn_sw_dev_in

Interface
REQ-001 The block SHALL have the parameter DB_CYCLES, default 100000, giving the debounce settle time in clk cycles (1 ms at 100 MHz); the minimum legal value is 2.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single system clock; all flops are rising-edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have the port sw_in, input, 8 bits: raw slide switches, asynchronous to clk.
REQ-005 The block SHALL have the port btn_in, input, 5 bits: raw push buttons, asynchronous to clk, 1 = pressed.
REQ-006 The block SHALL have the port GPIOe0000000_we, input, 1 bit: CPU write strobe for this device, one cycle wide.
REQ-007 The block SHALL have the port addr_sel, input, 2 bits: register select for both reads and writes.
REQ-008 The block SHALL have the port Peripheral_in, input, 32 bits: CPU write data.
REQ-009 The block SHALL have the port Peripheral_out, output, 32 bits: registered CPU read data.
REQ-010 The block SHALL have the port btn_irq, output, 1 bit: registered, level interrupt request.

Function
REQ-011 Each sw_in and btn_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce (per bit): while synced != stable, the bit's counter SHALL increment each cycle; when the counter reaches DB_CYCLES-1, stable SHALL take the synced value and the counter SHALL clear.
REQ-013 Debounce (per bit): whenever synced == stable, the counter SHALL clear, so a glitch shorter than DB_CYCLES never changes stable.
REQ-014 The counter width SHALL be $clog2(DB_CYCLES), and the counter SHALL never wrap.
REQ-015 Edge capture: a 0->1 transition of btn_stable[i] SHALL set capture[i] in the next cycle; capture bits are sticky.
REQ-016 Clear: when we=1 and addr_sel=01, every capture[i] with Peripheral_in[i]=1 SHALL clear (write-1-to-clear); bits written 0 SHALL be unaffected.
REQ-017 On a simultaneous new edge and clear of the same bit, set SHALL win and the bit stays 1.
REQ-018 When we=1 and addr_sel=10, irq_en SHALL load Peripheral_in[0].
REQ-019 Writes with addr_sel=00 or 11 SHALL have no effect.
REQ-020 Reads SHALL be continuous and registered, with 1-cycle latency from addr_sel to Peripheral_out.
REQ-021 Read map, addr_sel=00: Peripheral_out SHALL be {19'b0, btn_stable[4:0], sw_stable[7:0]}.
REQ-022 Read map, addr_sel=01: Peripheral_out SHALL be {27'b0, capture[4:0]}.
REQ-023 Read map, addr_sel=10: Peripheral_out SHALL be {31'b0, irq_en}.
REQ-024 Read map, addr_sel=11: Peripheral_out SHALL be 32'h0.
REQ-025 A read in the same cycle as a write SHALL return the pre-write value; the updated value appears one cycle later.
REQ-026 btn_irq SHALL be registered as irq_en & (|capture), giving a 1-cycle lag after capture or irq_en changes.
REQ-027 Total latency from a raw button press to capture set SHALL be 2 (sync) + DB_CYCLES + 1 cycles.

Reset
REQ-028 rst=1 SHALL asynchronously clear the synchronizers, stable, counters, capture, irq_en, Peripheral_out (32'h0) and btn_irq (0).
REQ-029 Reset asserted mid-debounce SHALL abort the debounce; after release, an already-held input SHALL require the full settle time again.
REQ-030 Because stable resets to 0, a button held through reset SHALL produce a capture once settled.

Structure
REQ-031 A shared package SHALL hold the addr_sel encodings (ADDR_STAT=00, ADDR_CAPT=01, ADDR_IRQEN=10) and the widths N_SW=8 and N_BTN=5.
REQ-032 A single-bit sub-module, debounce_bit (synchronizer, counter and stable flop), SHALL be instantiated 13 times.

Verification (DB_CYCLES=4 for simulation)
REQ-033 Hold sw_in=8'hA5 for 10 cycles, then read addr 00 -> Peripheral_out=32'h000000A5.
REQ-034 Pulse btn_in[2] for 3 synced cycles -> btn_stable and capture stay 0; hold it for 6 cycles -> capture=5'b00100 after 7 cycles.
REQ-035 With capture=5'b10100, write addr 01 data 32'h04 -> capture=5'b10000; a write that coincides with a new btn[4] edge leaves bit 4 at 1.
REQ-036 Write addr 10 data 1 with capture nonzero -> btn_irq=1 one cycle later; clear all capture bits -> btn_irq=0 one cycle later.
REQ-037 Assert rst mid-settle on btn[0] -> all outputs 0 immediately; after release with btn[0] still held -> capture[0]=1 after 7 cycles.
